mr_regsb: RTL and testbench
===========================

Name: mr_regsb

Overview:
- Parametrised register file plus write-pending scoreboard for the mr core's decode stage.
- Generalises decode-local regfile/hazard logic:
  - configurable register count, XLEN and read-port count;
  - wider pending counters with overflow refusal;
  - optional writeback-to-read bypass;
  - pipeline flush that discards in-flight pending writes;
  - multi-outstanding branch tracking.
- Decode drives read addresses and allocation requests; WB drives the write port.

Parameters:
- XLEN, 32, data width.
- NREGS, 32, architectural registers including x0; power of two, 2..64.
- NRD, 2, number of combinational read ports.
- PEND_BITS, 2, pending-write counter width per register; saturates at 2^PEND_BITS-1.
- BYPASS, 1, when 1 a same-cycle writeback retiring the last pending write is forwarded to reads.
- MAX_BR, 1, maximum outstanding unresolved branches/jumps (1..15).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rd_addr  in  NRD*$clog2(NREGS)  read addresses; port k at slice k.
- rd_data  out  NRD*XLEN  read data for port k.
- rd_busy  out  NRD  port k has an outstanding write not satisfied by bypass.
- alloc_valid  in  1  decode issues an instruction writing alloc_reg.
- alloc_reg  in  $clog2(NREGS)  destination register.
- alloc_ok  out  1  combinational: allocation will be accepted this cycle.
- br_alloc  in  1  decode issues a branch/jump.
- br_busy  out  1  outstanding branch count equals MAX_BR.
- br_done  in  1  a branch/jump resolved.
- wb_valid  in  1  writeback valid.
- wb_reg  in  $clog2(NREGS)  writeback register.
- wb_val  in  XLEN  writeback data.
- flush  in  1  discard all in-flight writes and branches.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=1 at posedge):
  - All registers become 0, all pending counters 0, branch count 0, err 0.
  - alloc_ok=0 and br_busy=1 while rst is high. rd_busy follows counters (0 after reset).
  - Reset dominates every other input in the same cycle.
- Reads (combinational, zero latency):
  - Address 0: rd_data=0, rd_busy=0.
  - Otherwise rd_data=regfile[a] and rd_busy=(pend[a]!=0).
  - If BYPASS=1, wb_valid, wb_reg==a!=0, and pend[a]==1: rd_data=wb_val and rd_busy=0.
- Allocation:
  - alloc_ok = !rst & (alloc_reg==0 | pend[alloc_reg] != max).
  - If alloc_valid&alloc_ok and alloc_reg!=0: pend+1 at the next edge.
  - alloc_valid with alloc_ok=0 is ignored, and err is not set; decode must stall.
  - alloc_reg==0 never changes state.
- Writeback:
  - If wb_valid and wb_reg!=0: regfile[wb_reg]<=wb_val.
  - If pend[wb_reg]!=0, pend-1.
  - If pend[wb_reg] was 0 the data is still written, the counter stays 0, and err<=1.
  - wb_reg==0 is ignored entirely.
- Same register allocated and written back in one cycle: the counter is unchanged (net 0) and data is written. If the counter was 0, the increment wins (result 1) and err is not set.
- Branch counter:
  - br_alloc increments the count; br_done decrements it.
  - Both in the same cycle: count unchanged.
  - br_alloc at MAX_BR: ignored, err<=1.
  - br_done at 0: ignored, err<=1.
- Flush:
  - All pending counters and the branch count become 0 at the next edge.
  - Register contents are kept. A wb in the same cycle still writes data.
  - alloc and br_alloc in the flush cycle are dropped.
  - err is unaffected.
- err clears only on rst.
- Writes to different registers in the same cycle are independent. There is one write port, so there are no write-write conflicts.

Test Plan:
- Reset then read x0..x31 on both ports -> all rd_data=0 and rd_busy=0; alloc_ok=0 during rst and 1 after.
- alloc x5 (cycle 0), wb x5=0xDEADBEEF (cycle 3) -> rd_busy[x5]=1 in cycles 1-3; with BYPASS=1 rd_data=0xDEADBEEF and busy=0 combinationally in cycle 3; stored value read in cycle 4.
- Allocate x7 three times (PEND_BITS=2) -> alloc_ok=0 on a 4th attempt; three wbs -> busy clears after the 3rd; err=0.
- alloc x9 together with wb x9=0x1234 while pend[x9]=1 -> pend stays 1, x9 reads 0x1234 with busy=1.
- wb x3 with pend=0 -> x3 updated and err=1 sticky. br_done with count 0 -> err stays 1, count stays 0.
- MAX_BR=2: two br_alloc -> br_busy=1; pend x4=2 then flush -> all busy=0, br_busy=0, x4 contents retained.

Source files
------------

// File: rtl/mr_regsb.sv
// Decode-stage register file with per-register pending-write counters,
// optional writeback bypass, flush, and outstanding-branch tracking.
module mr_regsb #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int PEND_BITS = 2,
    parameter int BYPASS    = 1,
    parameter int MAX_BR    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NRD*$clog2(NREGS)-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]           rd_data,
    output logic [NRD-1:0]                rd_busy,
    input  logic                          alloc_valid,
    input  logic [$clog2(NREGS)-1:0]      alloc_reg,
    output logic                          alloc_ok,
    input  logic                          br_alloc,
    output logic                          br_busy,
    input  logic                          br_done,
    input  logic                          wb_valid,
    input  logic [$clog2(NREGS)-1:0]      wb_reg,
    input  logic [XLEN-1:0]               wb_val,
    input  logic                          flush,
    output logic                          err
);

    localparam int AW  = $clog2(NREGS);
    localparam int BRW = $clog2(MAX_BR + 1);
    localparam logic [PEND_BITS-1:0] PEND_MAX = {PEND_BITS{1'b1}};

    logic [XLEN-1:0]      regs [NREGS];
    logic [PEND_BITS-1:0] pend [NREGS];
    logic [BRW-1:0]       br_cnt;

    logic             alloc_fire;
    logic             wb_fire;
    logic             wb_err;
    logic             br_full;
    logic             br_ovf;
    logic             br_udf;
    logic [NREGS-1:0] inc_v;
    logic [NREGS-1:0] dec_v;

    assign alloc_ok   = !rst && ((alloc_reg == '0) || (pend[alloc_reg] != PEND_MAX));
    assign alloc_fire = alloc_valid && alloc_ok && (alloc_reg != '0);
    assign wb_fire    = wb_valid && (wb_reg != '0);

    // A writeback to an idle register is only legal when the same cycle allocates it.
    assign wb_err = wb_fire && (pend[wb_reg] == '0) && !(alloc_fire && (alloc_reg == wb_reg));

    assign br_full = (br_cnt == BRW'(MAX_BR));
    assign br_busy = rst || br_full;
    assign br_ovf  = !flush && br_alloc && !br_done && br_full;
    assign br_udf  = !flush && br_done && !br_alloc && (br_cnt == '0);

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        if (alloc_fire)
            inc_v[alloc_reg] = 1'b1;
        if (wb_fire && (pend[wb_reg] != '0))
            dec_v[wb_reg] = 1'b1;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] a;
        logic          fwd;
        assign a   = rd_addr[k*AW +: AW];
        assign fwd = (BYPASS != 0) && wb_valid && (wb_reg == a) && (pend[a] == PEND_BITS'(1));
        assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0 : (fwd ? wb_val : regs[a]);
        assign rd_busy[k] = (a != '0) && !fwd && (pend[a] != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
                pend[i] <= '0;
            end
            br_cnt <= '0;
            err    <= 1'b0;
        end else begin
            if (wb_fire)
                regs[wb_reg] <= wb_val;

            // Simultaneous inc and dec on one register cancel out.
            for (int i = 0; i < NREGS; i++) begin
                if (flush)
                    pend[i] <= '0;
                else if (inc_v[i] && !dec_v[i])
                    pend[i] <= pend[i] + 1'b1;
                else if (dec_v[i] && !inc_v[i])
                    pend[i] <= pend[i] - 1'b1;
            end

            if (flush)
                br_cnt <= '0;
            else if (br_alloc && !br_done && !br_full)
                br_cnt <= br_cnt + 1'b1;
            else if (br_done && !br_alloc && (br_cnt != '0))
                br_cnt <= br_cnt - 1'b1;

            if (wb_err || br_ovf || br_udf)
                err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mr_regsb.sv
// Self-checking bench for mr_regsb: directed scenarios followed by randomized
// traffic compared against a behavioural model of the register/scoreboard rules.
module tb_mr_regsb;

    localparam int MAXBR = 2;
    localparam int PMAX  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        alloc_valid;
    logic [4:0]  alloc_reg;
    logic        alloc_ok;
    logic        br_alloc;
    logic        br_busy;
    logic        br_done;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_val;
    logic        flush;
    logic        err;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] mregs [32];
    int          mpend [32];
    int          mbr;
    bit          merr;

    mr_regsb #(
        .XLEN(32), .NREGS(32), .NRD(2), .PEND_BITS(2), .BYPASS(1), .MAX_BR(MAXBR)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .alloc_valid(alloc_valid), .alloc_reg(alloc_reg), .alloc_ok(alloc_ok),
        .br_alloc(br_alloc), .br_busy(br_busy), .br_done(br_done),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_val(wb_val),
        .flush(flush), .err(err)
    );

    always #5 clk = ~clk;

    function automatic bit m_alloc_ok();
        return !rst && (alloc_reg == 0 || mpend[alloc_reg] != PMAX);
    endfunction

    function automatic logic [31:0] m_rd_data(input logic [4:0] a);
        if (a == 0) return 32'h0;
        if (wb_valid && wb_reg == a && mpend[a] == 1) return wb_val;
        return mregs[a];
    endfunction

    function automatic bit m_rd_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
        if (wb_valid && wb_reg == a && mpend[a] == 1) return 1'b0;
        return mpend[a] != 0;
    endfunction

    // Applies one clock edge of the architectural rules to the model.
    task automatic model_edge();
        bit ok_a, do_w;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mregs[i] = 32'h0;
                mpend[i] = 0;
            end
            mbr  = 0;
            merr = 1'b0;
            return;
        end
        ok_a = alloc_valid && m_alloc_ok() && alloc_reg != 0;
        do_w = wb_valid && wb_reg != 0;
        if (do_w && mpend[wb_reg] == 0 && !(ok_a && alloc_reg == wb_reg))
            merr = 1'b1;
        if (do_w)
            mregs[wb_reg] = wb_val;
        if (flush) begin
            for (int i = 0; i < 32; i++) mpend[i] = 0;
            mbr = 0;
            return;
        end
        if (ok_a && do_w && alloc_reg == wb_reg) begin
            if (mpend[wb_reg] == 0) mpend[wb_reg] = 1;
        end else begin
            if (do_w && mpend[wb_reg] > 0) mpend[wb_reg]--;
            if (ok_a) mpend[alloc_reg]++;
        end
        if (br_alloc && !br_done) begin
            if (mbr == MAXBR) merr = 1'b1; else mbr++;
        end else if (br_done && !br_alloc) begin
            if (mbr == 0) merr = 1'b1; else mbr--;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_reg = 5'd0;
        br_alloc = 1'b0; br_done = 1'b0;
        wb_valid = 1'b0; wb_reg = 5'd0; wb_val = 32'h0;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_addr = 10'd0;
        idle_inputs();
        tick();
        tick();
        nvec++;
        if (alloc_ok !== 1'b0) begin nerr++; $display("FAIL reset_alloc_ok got %b exp 0", alloc_ok); end
        nvec++;
        if (br_busy !== 1'b1) begin nerr++; $display("FAIL reset_br_busy got %b exp 1", br_busy); end
        nvec++;
        if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b exp 0", err); end
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rd_addr = {5'(31 - a), 5'(a)};
            #1;
            nvec++;
            if (rd_data !== 64'h0 || rd_busy !== 2'b00) begin
                nerr++;
                $display("FAIL reset_read x%0d got data %h busy %b exp 0/00", a, rd_data, rd_busy);
            end
        end
        alloc_reg = 5'd5;
        #1;
        nvec++;
        if (alloc_ok !== 1'b1) begin nerr++; $display("FAIL post_reset_alloc_ok got %b exp 1", alloc_ok); end
        nvec++;
        if (br_busy !== 1'b0) begin nerr++; $display("FAIL post_reset_br_busy got %b exp 0", br_busy); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        rd_addr = {5'd5, 5'd5};
        alloc_valid = 1'b1; alloc_reg = 5'd5;
        tick();
        alloc_valid = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            nvec++;
            if (rd_busy !== 2'b11) begin nerr++; $display("FAIL bypass_busy_c%0d got %b exp 11", c, rd_busy); end
            tick();
        end
        wb_valid = 1'b1; wb_reg = 5'd5; wb_val = 32'hDEADBEEF;
        #1;
        nvec++;
        if (rd_data[31:0] !== 32'hDEADBEEF || rd_busy !== 2'b00) begin
            nerr++;
            $display("FAIL bypass_fwd got %h/%b exp deadbeef/00", rd_data[31:0], rd_busy);
        end
        tick();
        wb_valid = 1'b0;
        #1;
        nvec++;
        if (rd_data[63:32] !== 32'hDEADBEEF || rd_busy !== 2'b00) begin
            nerr++;
            $display("FAIL bypass_stored got %h/%b exp deadbeef/00", rd_data[63:32], rd_busy);
        end
    endtask

    task automatic test_saturate();
        idle_inputs();
        rd_addr = {5'd7, 5'd7};
        alloc_reg = 5'd7;
        alloc_valid = 1'b1;
        for (int j = 0; j < 3; j++) begin
            #1;
            nvec++;
            if (alloc_ok !== 1'b1) begin nerr++; $display("FAIL sat_alloc_ok_%0d got %b exp 1", j, alloc_ok); end
            tick();
        end
        #1;
        nvec++;
        if (alloc_ok !== 1'b0) begin nerr++; $display("FAIL sat_alloc_full got %b exp 0", alloc_ok); end
        tick();
        alloc_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            wb_valid = 1'b1; wb_reg = 5'd7; wb_val = 32'h700 + 32'(j);
            tick();
            wb_valid = 1'b0;
            #1;
            nvec++;
            if (rd_busy[0] !== (j < 2)) begin nerr++; $display("FAIL sat_busy_after_wb%0d got %b exp %b", j, rd_busy[0], (j < 2)); end
        end
        nvec++;
        if (rd_data[31:0] !== 32'h702) begin nerr++; $display("FAIL sat_data got %h exp 702", rd_data[31:0]); end
        nvec++;
        if (err !== 1'b0) begin nerr++; $display("FAIL sat_err got %b exp 0", err); end
    endtask

    task automatic test_same_cycle();
        idle_inputs();
        rd_addr = {5'd9, 5'd9};
        alloc_valid = 1'b1; alloc_reg = 5'd9;
        tick();
        wb_valid = 1'b1; wb_reg = 5'd9; wb_val = 32'h1234;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (rd_data[31:0] !== 32'h1234 || rd_busy !== 2'b11) begin
            nerr++;
            $display("FAIL same_cycle got %h/%b exp 1234/11", rd_data[31:0], rd_busy);
        end
        wb_valid = 1'b1; wb_reg = 5'd9; wb_val = 32'h5678;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (rd_busy !== 2'b00 || err !== 1'b0) begin
            nerr++;
            $display("FAIL same_cycle_drain got %b err %b exp 00 err 0", rd_busy, err);
        end
    endtask

    task automatic test_errors();
        idle_inputs();
        rd_addr = {5'd3, 5'd3};
        wb_valid = 1'b1; wb_reg = 5'd3; wb_val = 32'h33;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (rd_data[31:0] !== 32'h33) begin nerr++; $display("FAIL err_wb_data got %h exp 33", rd_data[31:0]); end
        nvec++;
        if (err !== 1'b1) begin nerr++; $display("FAIL err_wb_flag got %b exp 1", err); end
        br_done = 1'b1;
        tick();
        br_done = 1'b0;
        #1;
        nvec++;
        if (err !== 1'b1 || br_busy !== 1'b0) begin
            nerr++;
            $display("FAIL err_br_under got err %b br_busy %b exp 1/0", err, br_busy);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        rd_addr = {5'd4, 5'd4};
        br_alloc = 1'b1;
        tick();
        br_alloc = 1'b0;
        #1;
        nvec++;
        if (br_busy !== 1'b0) begin nerr++; $display("FAIL flush_br_one got %b exp 0", br_busy); end
        br_alloc = 1'b1;
        tick();
        br_alloc = 1'b0;
        #1;
        nvec++;
        if (br_busy !== 1'b1) begin nerr++; $display("FAIL flush_br_two got %b exp 1", br_busy); end
        alloc_valid = 1'b1; alloc_reg = 5'd4;
        tick();
        alloc_valid = 1'b0; wb_valid = 1'b1; wb_reg = 5'd4; wb_val = 32'hA5A5;
        tick();
        wb_valid = 1'b0; alloc_valid = 1'b1;
        tick();
        tick();
        alloc_valid = 1'b0;
        #1;
        nvec++;
        if (rd_busy !== 2'b11) begin nerr++; $display("FAIL flush_pre_busy got %b exp 11", rd_busy); end
        flush = 1'b1; alloc_valid = 1'b1; br_alloc = 1'b1;
        tick();
        idle_inputs();
        #1;
        nvec++;
        if (rd_busy !== 2'b00 || br_busy !== 1'b0) begin
            nerr++;
            $display("FAIL flush_clear got busy %b br_busy %b exp 00/0", rd_busy, br_busy);
        end
        nvec++;
        if (rd_data[31:0] !== 32'hA5A5) begin nerr++; $display("FAIL flush_keep got %h exp a5a5", rd_data[31:0]); end
        nvec++;
        if (err !== 1'b1) begin nerr++; $display("FAIL flush_err got %b exp 1", err); end
    endtask

    task automatic test_random();
        logic [4:0] a0, a1;
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(0, 149) == 0);
            flush       = ($urandom_range(0, 39) == 0);
            alloc_valid = $urandom_range(0, 1);
            alloc_reg   = 5'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 2) != 0) && !flush;
            wb_reg      = 5'($urandom_range(0, 7));
            wb_val      = $urandom;
            br_alloc    = ($urandom_range(0, 3) == 0);
            br_done     = ($urandom_range(0, 3) == 0);
            a0 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 7));
            rd_addr = {a1, a0};
            #1;
            nvec++;
            if (rd_data[31:0] !== m_rd_data(a0) || rd_busy[0] !== m_rd_busy(a0)) begin
                nerr++;
                $display("FAIL rnd_port0 n%0d x%0d got %h/%b exp %h/%b", n, a0, rd_data[31:0], rd_busy[0], m_rd_data(a0), m_rd_busy(a0));
            end
            nvec++;
            if (rd_data[63:32] !== m_rd_data(a1) || rd_busy[1] !== m_rd_busy(a1)) begin
                nerr++;
                $display("FAIL rnd_port1 n%0d x%0d got %h/%b exp %h/%b", n, a1, rd_data[63:32], rd_busy[1], m_rd_data(a1), m_rd_busy(a1));
            end
            nvec++;
            if (alloc_ok !== m_alloc_ok()) begin nerr++; $display("FAIL rnd_alloc_ok n%0d got %b exp %b", n, alloc_ok, m_alloc_ok()); end
            nvec++;
            if (br_busy !== (rst || mbr == MAXBR)) begin nerr++; $display("FAIL rnd_br_busy n%0d got %b exp %b", n, br_busy, (rst || mbr == MAXBR)); end
            nvec++;
            if (err !== merr) begin nerr++; $display("FAIL rnd_err n%0d got %b exp %b", n, err, merr); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_saturate();
        test_same_cycle();
        test_errors();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
